// File: rtl/mdio_read_seq_if.sv
// mdio_read_seq_if: register-file and MDIO capture-memory signals of the read sequencer.
// master is the sequencer view, slave the register-file/downstream view.
interface mdio_read_seq_if;
    logic        mdio_read_en;
    logic        rf_96path_en;
    logic        rf_rd_req;
    logic        rf_auto_inc_en;
    logic        rf_ptr_load;
    logic [6:0]  rf_start_sel;
    logic [14:0] rf_start_addr;
    logic [8:0]  rf_mdio_pkt_data;
    logic        rf_mdio_read_pulse;
    logic [6:0]  rf_mdio_data_sel;
    logic [14:0] rf_mdio_memory_addr;
    logic [8:0]  rf_rd_data;
    logic        rf_rd_valid;
    logic        rf_busy;
    logic        rf_seq_end;
    logic        rf_req_drop;

    modport master (
        input  mdio_read_en, rf_96path_en, rf_rd_req, rf_auto_inc_en, rf_ptr_load,
               rf_start_sel, rf_start_addr, rf_mdio_pkt_data,
        output rf_mdio_read_pulse, rf_mdio_data_sel, rf_mdio_memory_addr, rf_rd_data,
               rf_rd_valid, rf_busy, rf_seq_end, rf_req_drop
    );

    modport slave (
        output mdio_read_en, rf_96path_en, rf_rd_req, rf_auto_inc_en, rf_ptr_load,
               rf_start_sel, rf_start_addr, rf_mdio_pkt_data,
        input  rf_mdio_read_pulse, rf_mdio_data_sel, rf_mdio_memory_addr, rf_rd_data,
               rf_rd_valid, rf_busy, rf_seq_end, rf_req_drop
    );
endinterface

// File: rtl/mdio_read_seq.sv
// mdio_read_seq: turns host read requests into read pulses, waits RD_LAT cycles,
// latches the returned data and auto-advances the sel/addr pointer.
module mdio_read_seq #(
    parameter int RD_LAT = 2
) (
    input logic clk,
    input logic rstn,
    mdio_read_seq_if.master bus
);
    typedef enum logic [1:0] {IDLE, STRIKE, WAIT, CAPTURE} state_t;

    state_t      state, state_n;
    logic [2:0]  cnt, cnt_n;
    logic [6:0]  sel, sel_n;
    logic [14:0] addr, addr_n;
    logic [8:0]  data, data_n;
    logic        valid, valid_n;
    logic        seq_end, seq_end_n;
    logic        drop, drop_n;
    logic [6:0]  last;
    logic        at_end;

    assign last   = bus.rf_96path_en ? 7'd95 : 7'd47;
    // a start sel beyond LAST also counts as the end of the sequence
    assign at_end = (sel > last) || (sel == last && &addr);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        sel_n     = sel;
        addr_n    = addr;
        valid_n   = 1'b0;
        seq_end_n = seq_end;
        data_n    = bus.mdio_read_en ? data : 9'd0;
        drop_n    = drop | (bus.rf_rd_req & ~bus.rf_ptr_load &
                            ((state != IDLE) | seq_end | ~bus.mdio_read_en));
        if (bus.rf_ptr_load || !bus.mdio_read_en)
            state_n = IDLE;
        else
            case (state)
                IDLE:   state_n = (bus.rf_rd_req && !seq_end) ? STRIKE : IDLE;
                STRIKE: begin
                    state_n = WAIT;
                    cnt_n   = 3'(RD_LAT - 1);
                end
                WAIT:   begin
                    cnt_n   = cnt - 3'd1;
                    state_n = (cnt <= 3'd1) ? CAPTURE : WAIT;
                end
                default: begin
                    state_n   = IDLE;
                    data_n    = bus.rf_mdio_pkt_data;
                    valid_n   = 1'b1;
                    seq_end_n = seq_end | at_end;
                    if (bus.rf_auto_inc_en && !at_end)
                        {sel_n, addr_n} = {sel, addr} + 22'd1;
                end
            endcase
        if (bus.rf_ptr_load) begin
            sel_n     = bus.rf_start_sel;
            addr_n    = bus.rf_start_addr;
            seq_end_n = 1'b0;
            drop_n    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            sel     <= 7'd0;
            addr    <= 15'd0;
            data    <= 9'd0;
            valid   <= 1'b0;
            seq_end <= 1'b0;
            drop    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            sel     <= sel_n;
            addr    <= addr_n;
            data    <= data_n;
            valid   <= valid_n;
            seq_end <= seq_end_n;
            drop    <= drop_n;
        end
    end

    assign bus.rf_mdio_read_pulse  = (state == STRIKE);
    assign bus.rf_busy             = (state != IDLE);
    assign bus.rf_mdio_data_sel    = sel;
    assign bus.rf_mdio_memory_addr = addr;
    assign bus.rf_rd_data          = data;
    assign bus.rf_rd_valid         = valid;
    assign bus.rf_seq_end          = seq_end;
    assign bus.rf_req_drop         = drop;
endmodule
